// File: rtl/dplca_txop_table_ctrl_pkg.sv
// DPLCA TXOP table package: claim encodings, table selectors and controller state codes.
// Revision: 1.0
`default_nettype none

package dplca_txop_table_ctrl_pkg;

   localparam int unsigned TXOP_ID_WIDTH    = 8;
   localparam int unsigned TXOP_TABLE_DEPTH = 256;

   localparam logic [1:0] CLAIM_SOFT = 2'b00;
   localparam logic [1:0] CLAIM_HARD = 2'b01;
   localparam logic [1:0] CLAIM_NONE = 2'b10;

   // Bit positions inside clr_sel
   localparam int unsigned CLAIM_TABLE     = 0;
   localparam int unsigned CLAIM_TABLE_NEW = 1;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CLR_WALK = 3'd1;
   localparam logic [2:0] ST_AGE_WALK = 3'd2;
   localparam logic [2:0] ST_UPDATE   = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

`default_nettype wire

// File: rtl/dplca_txop_table_store.sv
// Storage for the CLAIM and CLAIM_NEW tables: one write port per table, registered lookup.
// Revision: 1.0
`default_nettype none

module dplca_txop_table_store
   import dplca_txop_table_ctrl_pkg::*;
#(
   parameter int TABLE_DEPTH = 256,
   parameter int ID_WIDTH    = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       claim_we,
   input  logic [ID_WIDTH-1:0]        claim_waddr,
   input  logic [1:0]                 claim_wdata,
   input  logic                       new_we,
   input  logic [ID_WIDTH-1:0]        new_waddr,
   input  logic [1:0]                 new_wdata,
   input  logic [ID_WIDTH-1:0]        new_rd_id,
   output logic [1:0]                 new_rd_data,
   input  logic [ID_WIDTH-1:0]        rd_id,
   output logic [1:0]                 rd_claim,
   output logic [2*TABLE_DEPTH-1:0]   claim_flat,
   output logic [2*TABLE_DEPTH-1:0]   new_flat
);

   logic [1:0] claim_mem [TABLE_DEPTH];
   logic [1:0] new_mem   [TABLE_DEPTH];

   // rd_claim samples before this cycle's write lands, giving read-before-write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            claim_mem[i] <= CLAIM_NONE;
            new_mem[i]   <= CLAIM_NONE;
         end
         rd_claim <= CLAIM_NONE;
      end else begin
         if (claim_we) claim_mem[claim_waddr] <= claim_wdata;
         if (new_we)   new_mem[new_waddr]     <= new_wdata;
         rd_claim <= claim_mem[rd_id];
      end
   end

   assign new_rd_data = new_mem[new_rd_id];

   for (genvar g = 0; g < TABLE_DEPTH; g++) begin : g_flat
      assign claim_flat[2*g +: 2] = claim_mem[g];
      assign new_flat[2*g +: 2]   = new_mem[g];
   end

endmodule

`default_nettype wire

// File: rtl/dplca_txop_table_ctrl.sv
// DPLCA TXOP claim-table controller: arbitrates clear / age / update and walks tables one entry per cycle.
// Revision: 1.0
`default_nettype none

module dplca_txop_table_ctrl
   import dplca_txop_table_ctrl_pkg::*;
#(
   parameter int TABLE_DEPTH = 256,
   parameter int ID_WIDTH    = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clr_req,
   input  logic [1:0]                 clr_sel,
   input  logic                       age_req,
   input  logic                       upd_req,
   input  logic [ID_WIDTH-1:0]        upd_id,
   input  logic [1:0]                 upd_val,
   output logic                       req_ack,
   output logic                       op_done,
   output logic                       busy,
   input  logic [ID_WIDTH-1:0]        rd_id,
   output logic [1:0]                 rd_claim,
   output logic [2*TABLE_DEPTH-1:0]   claim_table_unpacked,
   output logic [2*TABLE_DEPTH-1:0]   claim_table_new_unpacked
);

   logic [2:0]          state;
   logic [2:0]          state_nxt;
   logic [ID_WIDTH-1:0] idx;
   logic [1:0]          op_sel;
   logic [ID_WIDTH-1:0] op_id;
   logic [1:0]          op_val;
   logic                idx_last;

   logic                claim_we;
   logic                new_we;
   logic [ID_WIDTH-1:0] waddr;
   logic [1:0]          claim_wdata;
   logic [1:0]          new_wdata;
   logic [1:0]          new_at_idx;

   assign idx_last = &idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Operands are captured only for the request that wins arbitration
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx    <= '0;
         op_sel <= '0;
         op_id  <= '0;
         op_val <= CLAIM_NONE;
      end else if (state == ST_IDLE) begin
         idx <= '0;
         if (clr_req) begin
            op_sel <= clr_sel;
         end else if (!age_req && upd_req) begin
            op_id  <= upd_id;
            op_val <= upd_val;
         end
      end else if (state == ST_CLR_WALK || state == ST_AGE_WALK) begin
         idx <= idx + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (clr_req)      state_nxt = ST_CLR_WALK;
            else if (age_req) state_nxt = ST_AGE_WALK;
            else if (upd_req) state_nxt = ST_UPDATE;
         end
         ST_CLR_WALK,
         ST_AGE_WALK: if (idx_last) state_nxt = ST_DONE;
         ST_UPDATE:   state_nxt = ST_DONE;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ack     = (state == ST_IDLE) && (clr_req || age_req || upd_req);
      op_done     = (state == ST_DONE);
      busy        = (state != ST_IDLE);
      claim_we    = 1'b0;
      new_we      = 1'b0;
      waddr       = idx;
      claim_wdata = CLAIM_NONE;
      new_wdata   = CLAIM_NONE;
      case (state)
         ST_CLR_WALK: begin
            claim_we = op_sel[CLAIM_TABLE];
            new_we   = op_sel[CLAIM_TABLE_NEW];
         end
         ST_AGE_WALK: begin
            claim_we    = 1'b1;
            new_we      = 1'b1;
            claim_wdata = new_at_idx;
         end
         ST_UPDATE: begin
            claim_we    = 1'b1;
            new_we      = 1'b1;
            waddr       = op_id;
            claim_wdata = op_val;
            new_wdata   = op_val;
         end
         default: ;
      endcase
   end

   dplca_txop_table_store #(
      .TABLE_DEPTH (TABLE_DEPTH),
      .ID_WIDTH    (ID_WIDTH)
   ) u_store (
      .clk         (clk),
      .reset_n     (reset_n),
      .claim_we    (claim_we),
      .claim_waddr (waddr),
      .claim_wdata (claim_wdata),
      .new_we      (new_we),
      .new_waddr   (waddr),
      .new_wdata   (new_wdata),
      .new_rd_id   (idx),
      .new_rd_data (new_at_idx),
      .rd_id       (rd_id),
      .rd_claim    (rd_claim),
      .claim_flat  (claim_table_unpacked),
      .new_flat    (claim_table_new_unpacked)
   );

endmodule

`default_nettype wire

// File: tb/tb_dplca_txop_table_ctrl.sv
// Self-checking bench for dplca_txop_table_ctrl against a table-level reference model.
// Revision: 1.0
`default_nettype none

module tb_dplca_txop_table_ctrl;

   localparam logic [1:0] SOFT = 2'b00;
   localparam logic [1:0] HARD = 2'b01;
   localparam logic [1:0] NONE = 2'b10;
   localparam int K_CLR = 0;
   localparam int K_AGE = 1;
   localparam int K_UPD = 2;

   logic         clk;
   logic         reset_n;
   logic         clr_req;
   logic [1:0]   clr_sel;
   logic         age_req;
   logic         upd_req;
   logic [7:0]   upd_id;
   logic [1:0]   upd_val;
   logic         req_ack;
   logic         op_done;
   logic         busy;
   logic [7:0]   rd_id;
   logic [1:0]   rd_claim;
   logic [511:0] claim_flat;
   logic [511:0] new_flat;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [1:0] m_claim [256];
   logic [1:0] m_new   [256];

   dplca_txop_table_ctrl #(
      .TABLE_DEPTH (256),
      .ID_WIDTH    (8)
   ) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .clr_req                  (clr_req),
      .clr_sel                  (clr_sel),
      .age_req                  (age_req),
      .upd_req                  (upd_req),
      .upd_id                   (upd_id),
      .upd_val                  (upd_val),
      .req_ack                  (req_ack),
      .op_done                  (op_done),
      .busy                     (busy),
      .rd_id                    (rd_id),
      .rd_claim                 (rd_claim),
      .claim_table_unpacked     (claim_flat),
      .claim_table_new_unpacked (new_flat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] flat_model(input bit which_new);
      logic [511:0] v;
      for (int i = 0; i < 256; i++) v[2*i +: 2] = which_new ? m_new[i] : m_claim[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) begin
         m_claim[i] = NONE;
         m_new[i]   = NONE;
      end
   endtask

   task automatic model_apply(input int kind, input logic [1:0] sel, input logic [7:0] id, input logic [1:0] val);
      case (kind)
         K_CLR: for (int i = 0; i < 256; i++) begin
            if (sel[0]) m_claim[i] = NONE;
            if (sel[1]) m_new[i]   = NONE;
         end
         K_AGE: for (int i = 0; i < 256; i++) begin
            m_claim[i] = m_new[i];
            m_new[i]   = NONE;
         end
         default: begin
            m_claim[id] = val;
            m_new[id]   = val;
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, waits (bounded) for its ack and op_done; returns at the op_done negedge.
   task automatic run_op(input int kind, input logic [1:0] sel, input logic [7:0] id, input logic [1:0] val,
                         output int ack_c, output int done_c, output bit timed_out);
      ack_c = -1;
      done_c = -1;
      timed_out = 1'b0;
      tick();
      case (kind)
         K_CLR: begin clr_req = 1'b1; clr_sel = sel; end
         K_AGE: age_req = 1'b1;
         default: begin upd_req = 1'b1; upd_id = id; upd_val = val; end
      endcase
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (req_ack) begin ack_c = cyc; break; end
      end
      tick();
      clr_req = 1'b0;
      age_req = 1'b0;
      upd_req = 1'b0;
      if (ack_c >= 0) begin
         for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (op_done) begin done_c = cyc; break; end
         end
      end
      if (ack_c < 0 || done_c < 0) timed_out = 1'b1;
      else model_apply(kind, sel, id, val);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      model_reset();
      reset_n = 1'b1;
      tick();
      checks++;
      if (claim_flat !== {256{2'b10}}) begin errors++; $display("FAIL reset_claim got=%h exp=all-NONE", claim_flat); end
      checks++;
      if (new_flat !== {256{2'b10}}) begin errors++; $display("FAIL reset_claim_new got=%h exp=all-NONE", new_flat); end
      checks++;
      if (rd_claim !== NONE) begin errors++; $display("FAIL reset_rd_claim got=%b exp=%b", rd_claim, NONE); end
      checks++;
      if ({busy, op_done, req_ack} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got busy/done/ack=%b exp=000", {busy, op_done, req_ack});
      end
   endtask

   task automatic test_update();
      int a, d;
      bit to;
      rd_id = 8'h05;
      run_op(K_UPD, 2'b00, 8'h05, HARD, a, d, to);
      checks++;
      if (to || (d - a) != 2) begin errors++; $display("FAIL upd_latency got=%0d timeout=%0d exp=2", d - a, to); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL upd_busy_at_done got=%b exp=1", busy); end
      checks++;
      if (rd_claim !== NONE) begin errors++; $display("FAIL upd_read_before_write got=%b exp=%b", rd_claim, NONE); end
      tick();
      checks++;
      if (claim_flat[11:10] !== HARD || new_flat[11:10] !== HARD) begin
         errors++; $display("FAIL upd_entry5 got claim=%b new=%b exp=%b", claim_flat[11:10], new_flat[11:10], HARD);
      end
      checks++;
      if (rd_claim !== HARD) begin errors++; $display("FAIL upd_rd_claim got=%b exp=%b", rd_claim, HARD); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL upd_busy_after got=%b exp=0", busy); end
      checks++;
      if (claim_flat !== flat_model(1'b0) || new_flat !== flat_model(1'b1)) begin
         errors++; $display("FAIL upd_tables got claim=%h exp=%h", claim_flat, flat_model(1'b0));
      end
   endtask

   task automatic test_age();
      int a, d;
      bit to0, to1, to;
      run_op(K_UPD, 2'b00, 8'h00, HARD, a, d, to0);
      run_op(K_UPD, 2'b00, 8'hFF, SOFT, a, d, to1);
      run_op(K_AGE, 2'b00, 8'h00, NONE, a, d, to);
      checks++;
      if (to0 || to1 || to || (d - a) != 257) begin
         errors++; $display("FAIL age_latency got=%0d timeouts=%0d%0d%0d exp=257", d - a, to0, to1, to);
      end
      tick();
      checks++;
      if (claim_flat[1:0] !== HARD || claim_flat[511:510] !== SOFT) begin
         errors++; $display("FAIL age_claim_ends got [1:0]=%b [511:510]=%b exp=01/00", claim_flat[1:0], claim_flat[511:510]);
      end
      checks++;
      if (new_flat !== {256{2'b10}}) begin errors++; $display("FAIL age_new_cleared got=%h exp=all-NONE", new_flat); end
      checks++;
      if (claim_flat !== flat_model(1'b0)) begin errors++; $display("FAIL age_claim got=%h exp=%h", claim_flat, flat_model(1'b0)); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL age_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_priority();
      int a, d, acks, dones, extra;
      int ack_c [3];
      int done_c [3];
      int acc;
      bit to;
      logic [7:0] id;
      logic [1:0] val;
      for (int k = 0; k < 4; k++) begin
         run_op(K_UPD, 2'b00, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 1)), a, d, to);
         checks++;
         if (to) begin errors++; $display("FAIL prio_preload timeout got=1 exp=0"); end
      end
      id  = 8'($urandom_range(0, 255));
      val = 2'($urandom_range(0, 1));
      acks = 0;
      dones = 0;
      tick();
      clr_req = 1'b1; clr_sel = 2'b01; age_req = 1'b1; upd_req = 1'b1; upd_id = id; upd_val = val;
      for (int n = 0; n < 1200 && dones < 3; n++) begin
         @(negedge clk);
         acc = -1;
         if (req_ack) begin
            if (acks < 3) ack_c[acks] = cyc;
            acc = clr_req ? K_CLR : (age_req ? K_AGE : K_UPD);
            acks++;
         end
         if (op_done) begin
            if (dones < 3) done_c[dones] = cyc;
            dones++;
         end
         tick();
         if (acc == K_CLR) clr_req = 1'b0;
         if (acc == K_AGE) age_req = 1'b0;
         if (acc == K_UPD) upd_req = 1'b0;
      end
      clr_req = 1'b0; age_req = 1'b0; upd_req = 1'b0;
      extra = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (req_ack || op_done) extra++;
      end
      checks++;
      if (acks != 3 || dones != 3 || extra != 0) begin
         errors++; $display("FAIL prio_pulses got acks=%0d dones=%0d extra=%0d exp=3/3/0", acks, dones, extra);
      end
      if (acks >= 3 && dones >= 3) begin
         checks++;
         if (done_c[0] - ack_c[0] != 257 || ack_c[1] != done_c[0] + 1 || done_c[1] - ack_c[1] != 257) begin
            errors++; $display("FAIL prio_timing_1 got ack0=%0d done0=%0d ack1=%0d done1=%0d", ack_c[0], done_c[0], ack_c[1], done_c[1]);
         end
         checks++;
         if (ack_c[2] != done_c[1] + 1 || done_c[2] - ack_c[2] != 2) begin
            errors++; $display("FAIL prio_timing_2 got ack2=%0d done1=%0d done2=%0d", ack_c[2], done_c[1], done_c[2]);
         end
      end
      model_apply(K_CLR, 2'b01, 8'h00, NONE);
      model_apply(K_AGE, 2'b00, 8'h00, NONE);
      model_apply(K_UPD, 2'b00, id, val);
      checks++;
      if (claim_flat !== flat_model(1'b0) || new_flat !== flat_model(1'b1)) begin
         errors++; $display("FAIL prio_tables got claim=%h exp=%h", claim_flat, flat_model(1'b0));
      end
   endtask

   task automatic test_mid_walk_request();
      int t_ack, walk_done, upd_ack, upd_done;
      logic [7:0] id;
      logic [1:0] val;
      id  = 8'($urandom_range(0, 255));
      val = 2'($urandom_range(0, 1));
      t_ack = -1; walk_done = -1; upd_ack = -1; upd_done = -1;
      tick();
      clr_req = 1'b1; clr_sel = 2'b11;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ack) begin t_ack = cyc; break; end
      end
      tick();
      clr_req = 1'b0;
      for (int n = 0; n < 20 && cyc < t_ack + 10; n++) tick();
      upd_req = 1'b1; upd_id = id; upd_val = val;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (req_ack && upd_ack < 0) upd_ack = cyc;
         if (op_done) begin
            if (walk_done < 0) walk_done = cyc;
            else if (upd_done < 0) upd_done = cyc;
         end
         if (upd_done >= 0) break;
         tick();
         if (upd_ack >= 0) upd_req = 1'b0;
      end
      upd_req = 1'b0;
      checks++;
      if (t_ack < 0 || walk_done != t_ack + 257) begin
         errors++; $display("FAIL midwalk_clear_done got=%0d exp=%0d", walk_done, t_ack + 257);
      end
      checks++;
      if (upd_ack != walk_done + 1 || upd_done != upd_ack + 2) begin
         errors++; $display("FAIL midwalk_upd_ack got ack=%0d done=%0d exp ack=%0d", upd_ack, upd_done, walk_done + 1);
      end
      model_apply(K_CLR, 2'b11, 8'h00, NONE);
      model_apply(K_UPD, 2'b00, id, val);
      tick();
      checks++;
      if (claim_flat !== flat_model(1'b0) || new_flat !== flat_model(1'b1)) begin
         errors++; $display("FAIL midwalk_tables got claim=%h exp=%h", claim_flat, flat_model(1'b0));
      end
   endtask

   task automatic test_reset_mid_walk();
      int a, d, t_ack, stray;
      bit to;
      logic [7:0] id;
      id = 8'($urandom_range(0, 255));
      run_op(K_UPD, 2'b00, id, HARD, a, d, to);
      t_ack = -1;
      tick();
      age_req = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ack) begin t_ack = cyc; break; end
      end
      tick();
      age_req = 1'b0;
      for (int n = 0; n < 200 && cyc < t_ack + 101; n++) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rstwalk_busy_before got=%b exp=1", busy); end
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (claim_flat !== {256{2'b10}} || new_flat !== {256{2'b10}}) begin
         errors++; $display("FAIL rstwalk_tables got claim=%h exp=all-NONE", claim_flat);
      end
      checks++;
      if (busy !== 1'b0 || op_done !== 1'b0) begin
         errors++; $display("FAIL rstwalk_flags got busy=%b done=%b exp=0/0", busy, op_done);
      end
      stray = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (op_done || busy) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL rstwalk_no_done got=%0d exp=0", stray); end
      run_op(K_UPD, 2'b00, id, SOFT, a, d, to);
      run_op(K_CLR, 2'b01, 8'h00, NONE, a, d, to);
      checks++;
      if (to || (d - a) != 257) begin errors++; $display("FAIL rstwalk_clear_latency got=%0d timeout=%0d exp=257", d - a, to); end
      tick();
      checks++;
      if (claim_flat !== flat_model(1'b0) || new_flat !== flat_model(1'b1)) begin
         errors++; $display("FAIL rstwalk_after_tables got new=%h exp=%h", new_flat, flat_model(1'b1));
      end
   endtask

   task automatic test_random();
      int a, d, kind, lat, r;
      bit to;
      logic [1:0] sel, val;
      logic [7:0] id;
      for (int it = 0; it < 14; it++) begin
         r = $urandom_range(0, 9);
         kind = (r < 6) ? K_UPD : ((r < 8) ? K_AGE : K_CLR);
         sel = 2'($urandom_range(0, 3));
         id  = 8'($urandom_range(0, 255));
         val = ($urandom_range(0, 1) == 0) ? SOFT : HARD;
         lat = (kind == K_UPD) ? 2 : 257;
         run_op(kind, sel, id, val, a, d, to);
         checks++;
         if (to || (d - a) != lat) begin errors++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, d - a, lat); end
         rd_id = 8'($urandom_range(0, 255));
         tick();
         checks++;
         if (claim_flat !== flat_model(1'b0) || new_flat !== flat_model(1'b1)) begin
            errors++; $display("FAIL rand_tables it=%0d got claim=%h exp=%h", it, claim_flat, flat_model(1'b0));
         end
         tick();
         checks++;
         if (rd_claim !== m_claim[rd_id]) begin
            errors++; $display("FAIL rand_rd_claim it=%0d got=%b exp=%b", it, rd_claim, m_claim[rd_id]);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      clr_req = 1'b0; clr_sel = 2'b00; age_req = 1'b0; upd_req = 1'b0;
      upd_id = 8'h00; upd_val = SOFT; rd_id = 8'h00;
      test_reset();
      test_update();
      test_age();
      test_priority();
      test_mid_walk_request();
      test_reset_mid_walk();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
